// File: rtl/key_filter_if.sv
// ---------------------------------------------------------------------------
// key_filter_if
//   Groups the push-button pin and the debounced event/level outputs of
//   key_filter into one bundle.
//
//   Signals:
//     key_in      raw button level, asynchronous, 0 = pressed
//     key_flag    one-cycle pulse on a debounced press
//     key_release one-cycle pulse on a debounced release
//     key_state   debounced level, 1 = held
//     led_out     LED drive, active-low (0 = lit)
//
//   Modports:
//     master  drives key_in, observes the filter results (board / testbench)
//     slave   the filter itself
// ---------------------------------------------------------------------------
interface key_filter_if;
  logic key_in;
  logic key_flag;
  logic key_release;
  logic key_state;
  logic led_out;

  modport master (
    output key_in,
    input  key_flag,
    input  key_release,
    input  key_state,
    input  led_out
  );

  modport slave (
    input  key_in,
    output key_flag,
    output key_release,
    output key_state,
    output led_out
  );
endinterface

// File: rtl/key_filter.sv
// ---------------------------------------------------------------------------
// key_filter
//   Debounces the active-low board push-button. The raw pin is synchronised,
//   then a four-state filter requires the synchronised level to hold for a
//   full window of CNT_MAX+2 consecutive samples before it is accepted as a
//   press or a release. Accepted transitions produce registered one-cycle
//   pulses plus a debounced level, and the board LED is driven from the
//   debounced result.
//
//   Parameters:
//     CNT_MAX    debounce window minus one, in sys_clk cycles (>= 1)
//
//   Ports:
//     sys_clk    system clock, rising edge
//     sys_rst_n  asynchronous active-low reset
//     kf         key_filter_if.slave: key_in in; key_flag, key_release,
//                key_state, led_out out (all outputs registered)
//
//   Build option:
//     KEY_FILTER_LED_TOGGLE_EN  defined: each debounced press toggles led_out.
//                               undefined: led_out is lit while the key is held.
// ---------------------------------------------------------------------------
module key_filter #(
  parameter int CNT_MAX = 999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  key_filter_if.slave kf
);

  localparam int CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILTER,
    DOWN,
    RELEASE_FILTER
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             key_sync;
  logic             flag_q, flag_d;
  logic             release_q, release_d;
  logic             held_q, held_d;
  logic             led_q, led_d;

  // Two-stage synchroniser; resets to the released (high) level so a reset
  // never looks like a press edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= kf.key_in;
      sync2_q <= sync1_q;
    end
  end

  assign key_sync = sync2_q;

  // State, counter and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      flag_q    <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
      led_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flag_q    <= flag_d;
      release_q <= release_d;
      held_q    <= held_d;
      led_q     <= led_d;
    end
  end

  // Next state. Any disagreement during a filter state restarts from the
  // stable state, so every bounce costs a full new window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!key_sync) begin
          state_d = PRESS_FILTER;
          cnt_d   = '0;
        end
      end
      PRESS_FILTER: begin
        if (key_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        if (key_sync) begin
          state_d = RELEASE_FILTER;
          cnt_d   = '0;
        end
      end
      RELEASE_FILTER: begin
        if (!key_sync) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values. The pulses are decoded from the completing filter
  // transition, so they land on the same edge as the move to DOWN / IDLE and
  // can never coincide.
  always_comb begin
    flag_d    = (state_q == PRESS_FILTER)   && !key_sync && (cnt_q == CNT_LAST);
    release_d = (state_q == RELEASE_FILTER) &&  key_sync && (cnt_q == CNT_LAST);
    held_d    = held_q;
    if (flag_d) begin
      held_d = 1'b1;
    end else if (release_d) begin
      held_d = 1'b0;
    end
`ifdef KEY_FILTER_LED_TOGGLE_EN
    led_d = flag_d ? ~led_q : led_q;
`else
    led_d = ~held_d;
`endif
  end

  assign kf.key_flag    = flag_q;
  assign kf.key_release = release_q;
  assign kf.key_state   = held_q;
  assign kf.led_out     = led_q;

endmodule

// File: doc/key_filter.md
# key_filter

Debounces the active-low board push-button and turns its bouncing level into clean, single-cycle press/release events plus a stable debounced level. The block sits between the raw `key_in` pin and downstream logic; it drives the board LED directly from the debounced result. It replaces raw per-clock sampling of the button, which passes contact bounce straight through to the output.

## Interface
Parameters:
- `CNT_MAX`, default 999_999: debounce window minus one, in `sys_clk` cycles. The default gives 20 ms at 50 MHz. Legal range is 1 or more.

Ports:
- `sys_clk`  in  1  50 MHz system clock; all logic is on the rising edge.
- `sys_rst_n`  in  1  reset; asynchronous, active-low.
- `key_in`  in  1  raw button, asynchronous; 0 = pressed.
- `key_flag`  out  1  one-cycle pulse on a debounced press.
- `key_release`  out  1  one-cycle pulse on a debounced release.
- `key_state`  out  1  debounced level; 1 = held.
- `led_out`  out  1  LED drive, active-low (0 = lit).

## Operation
- **Synchronizer.** Two flip-flops, both reset to 1. The output of the second is `key_sync`.
- **Counter.** `cnt` is ceil(log2(CNT_MAX+1)) bits wide and resets to 0. It never exceeds `CNT_MAX`, so it cannot wrap.
- **State machine.** States are IDLE, PRESS_FILTER, DOWN and RELEASE_FILTER. Reset state is IDLE.
  - IDLE: `key_sync`=0 → go to PRESS_FILTER with `cnt`=0. Otherwise stay.
  - PRESS_FILTER, `key_sync`=1: bounce. Go to IDLE with `cnt`=0 and no pulse.
  - PRESS_FILTER, `key_sync`=0 and `cnt`<`CNT_MAX`: increment `cnt`.
  - PRESS_FILTER, `key_sync`=0 and `cnt`==`CNT_MAX`: go to DOWN, `cnt`=0, `key_flag`=1, `key_state`=1.
  - DOWN: `key_sync`=1 → go to RELEASE_FILTER with `cnt`=0. Otherwise stay.
  - RELEASE_FILTER: mirrors PRESS_FILTER with polarity inverted.
    - Bounce (`key_sync`=0) returns to DOWN with no pulse.
    - Completion goes to IDLE with `key_release`=1 and `key_state`=0.
- **Pulses.** `key_flag` and `key_release` are registered and high for exactly one cycle. They are never high in the same cycle.
- **Reset values.** `key_flag`=0, `key_release`=0, `key_state`=0, `led_out`=1.
- **Reset mid-operation.** Any state returns to IDLE and `cnt` clears. No pulse is emitted during or after reset. A key held through reset release is re-filtered from the start and produces one `key_flag` after the full window.

## Timing
- **Press latency.** Count the `sys_clk` edge that first samples `key_in`=0 as edge 1. If `key_in` stays stable, `key_flag` is high in the cycle following edge CNT_MAX+4. `key_state` rises on that same edge.
- **Release latency.** Identical: CNT_MAX+4 edges from the first edge that samples `key_in`=1.
- **Glitch rejection.**
  - A low glitch shorter than CNT_MAX+1 cycles at `key_sync` produces no output.
  - Each bounce restarts the full window.
- **Back-to-back presses.** Minimum spacing between two `key_flag` pulses is 2×(CNT_MAX+2) cycles.
- **Output timing.** All outputs are registered, so there is no combinational path from `key_in`.

## Configuration
Macro `KEY_FILTER_LED_TOGGLE_EN`:
- **Defined:** `led_out` inverts on the same edge that raises `key_flag`, so each press toggles the LED. Releases do not affect it.
- **Undefined:** `led_out` = NOT `key_state`, registered on the same edge. The LED is lit exactly while the key is held (debounced).
- Reset value of `led_out` is 1 in both builds.

## Test plan
All scenarios use `CNT_MAX`=9.
- **Reset:** hold `sys_rst_n`=0 for 5 cycles. Expect all outputs at their reset values (`led_out`=1, all others 0) and state IDLE.
- **Clean press:** drive `key_in` 1→0 and hold for 30 cycles. Expect `key_flag` high for exactly one cycle after edge 13, `key_state`=1 from that edge, and `led_out`=0 in both builds.
- **Bouncy press:** toggle `key_in` low/high with 3-cycle pulses four times, then hold low.
  - Expect no pulse during the bounce.
  - Expect exactly one `key_flag` 13 edges after the final falling sample.
- **Clean release:** from DOWN, drive `key_in` 0→1. Expect `key_release` one cycle after edge 13 and `key_state`=0.
  - Toggle build: `led_out` unchanged.
  - Level build: `led_out`=1.
- **Reset mid-filter:** press, then assert reset at `cnt`=5 while the key stays held. After reset release, expect exactly one `key_flag` 13 edges after the first post-reset sampling edge.
- **Toggle build:** three clean press/release pairs. Expect `led_out` sequence 1→0→1→0, and exactly 3 `key_flag` and 3 `key_release` pulses.
